rr_bus_arbiter: RTL and testbench
=================================

Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-bit transmit channel among NUM_REQ transmitters and forwards the granted transmitter's beats to a single receiver over a valid/ready handshake.
- Sits between several tx-side producers and one rx-side consumer on the shared clocked bus.
- Bounds each grant to MAX_BURST accepted beats to guarantee fairness.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 3, width of one data beat.
- MAX_BURST, 4, maximum beats accepted per grant (>=1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-requester request; requester i holds req[i] high while it has data.
- req_data  input  NUM_REQ*DATA_W  packed beats; slice i is [i*DATA_W +: DATA_W]; held stable while req[i] is high and the beat is not yet accepted.
- gnt  output  NUM_REQ  registered one-hot grant; all zero when idle.
- out_valid  output  1  beat valid toward the receiver.
- out_data  output  DATA_W  beat toward the receiver.
- out_src  output  $clog2(NUM_REQ)  index of the current owner.
- out_ready  input  1  receiver accepts a beat when out_valid && out_ready.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values (and values after rst):
  - state = ARB_IDLE; gnt = 0; owner = 0.
  - ptr (round-robin pointer) = 0; beat_cnt = 0.
  - out_valid = 0; out_data = 0; out_src = 0.
- rst asserted mid-burst:
  - The in-flight beat is dropped even if out_ready is high that cycle.
  - gnt is all zero on the next edge.
- ARB_IDLE:
  - If any req bit is set, select the first set index scanning ptr, ptr+1, ... with wrap mod NUM_REQ.
  - Next edge: owner = that index, gnt = onehot(owner), beat_cnt = 0, state = ARB_BUSY.
  - If no req bit is set, stay in ARB_IDLE.
  - Grant latency: 1 cycle from req high (while idle) to gnt high.
- ARB_BUSY:
  - out_valid = req[owner], combinational and gated by state.
  - out_data = req_data slice for owner; out_src = owner.
  - Accept = out_valid && out_ready. Each accept increments beat_cnt.
- Release from ARB_BUSY:
  - (a) Accept while beat_cnt == MAX_BURST-1, or
  - (b) req[owner] == 0.
  - On release: state = ARB_IDLE, gnt = 0, ptr = (owner+1) mod NUM_REQ.
- Bus turnaround: exactly one idle cycle between consecutive grants.
- Back-pressure: while out_ready = 0, owner, gnt and beat_cnt are held indefinitely. No timeout.
- Non-owner req changes in ARB_BUSY are ignored until the next ARB_IDLE.
- Outputs in ARB_IDLE: out_valid = 0; out_data = 0 (not a don't-care).
- beat_cnt width: $clog2(MAX_BURST+1); it never exceeds MAX_BURST-1.

Optional Feature:
- Macro: RR_BUS_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest set req index always wins, ptr is not updated (it stays 0), and MAX_BURST limiting still applies.
- Undefined: round-robin as described above.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  - default constants ARB_NUM_REQ_DEF = 4, ARB_DATA_W_DEF = 3, ARB_MAX_BURST_DEF = 4.
- Sub-module rr_pick (purely combinational):
  - Inputs: req, ptr. Outputs: any, idx.
  - Rotate-and-priority-encode.
  - Instantiated once; the fixed-priority build ties ptr to 0.

Test Plan:
- Reset: rst high for 2 cycles with req = 4'b1111 -> gnt = 0, out_valid = 0, out_src = 0 throughout; first gnt = 4'b0001 one cycle after rst falls.
- Round-robin rotation: req = 4'b1111 held, out_ready = 1, MAX_BURST = 4 -> grants go 0,1,2,3,0, each with 4 accepts, then 1 idle cycle; out_data matches each slice.
- Early release: req[2] alone, deasserted after 2 accepts -> gnt[2] drops the cycle after req[2] falls, beat_cnt = 2 at release, ptr = 3.
- Back-pressure: owner 1 with out_ready = 0 for 5 cycles -> gnt = 4'b0010 and out_data stable, no accept counted; out_ready = 1 resumes the count at 0.
- Reset mid-burst: rst pulsed during owner 3's second beat with out_ready = 1 -> that beat is not accepted, gnt = 0 next cycle, ptr = 0, so requester 0 wins next.
- Fixed-prio build: with RR_BUS_ARBITER_FIXED_PRIO_EN defined and req = 4'b1010 held -> owner is always 1 and requester 3 is never granted.

Source files
------------

// File: rtl/rr_bus_arbiter_pkg.sv
// arb_pkg: shared types and defaults for the rr_bus_arbiter slice.
// Holds the arbiter state enum, default sizes and a wrap helper.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    localparam int ARB_NUM_REQ_DEF   = 4;
    localparam int ARB_DATA_W_DEF    = 3;
    localparam int ARB_MAX_BURST_DEF = 4;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_pick.sv
// rr_pick: combinational rotate-and-priority-encode.
// Ports: req (requests), ptr (start index) -> any, idx (first set from ptr).
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int PW = $clog2(N);

    int j;

    // Scan offsets from high to low so the smallest offset wins.
    always_comb begin
        any = |req;
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: shares one valid/ready channel among NUM_REQ sources,
// round-robin, with at most MAX_BURST accepted beats per grant.
// Ports: clk, rst (sync, active-high), req, req_data -> gnt,
//   out_valid, out_data, out_src; out_ready from the receiver.
// Build option: RR_BUS_ARBITER_FIXED_PRIO_EN selects fixed priority.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ   = ARB_NUM_REQ_DEF,
    parameter int DATA_W    = ARB_DATA_W_DEF,
    parameter int MAX_BURST = ARB_MAX_BURST_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
    input  logic                      out_ready
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     owner_nxt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_nxt;
    logic [PW-1:0]     pick_ptr;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     rel_ptr;
    logic              pick_any;
    logic [CW-1:0]     beat_cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              busy;
    logic              own_req;
    logic              accept;
    logic              last_beat;
    logic [DATA_W-1:0] own_data;

`ifdef RR_BUS_ARBITER_FIXED_PRIO_EN
    assign pick_ptr = '0;
    assign rel_ptr  = '0;
`else
    assign pick_ptr = ptr;
    assign rel_ptr  = PW'(wrap_inc(int'(owner), NUM_REQ));
`endif

    rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .req(req),
        .ptr(pick_ptr),
        .any(pick_any),
        .idx(pick_idx)
    );

    always_comb begin
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == PW'(i)) begin
                own_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // rst masks the channel so a beat in flight at reset is never
    // seen as accepted by the receiver.
    assign busy      = (state == ARB_BUSY);
    assign own_req   = req[owner];
    assign out_valid = busy & own_req & ~rst;
    assign out_data  = (busy & ~rst) ? own_data : '0;
    assign out_src   = owner;
    assign accept    = out_valid & out_ready;
    assign last_beat = (beat_cnt == CW'(MAX_BURST - 1));

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = beat_cnt;
        unique case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_nxt = ARB_BUSY;
                    owner_nxt = pick_idx;
                    gnt_nxt   = NUM_REQ'(1) << pick_idx;
                    cnt_nxt   = '0;
                end
            end
            ARB_BUSY: begin
                if (!own_req || (accept && last_beat)) begin
                    state_nxt = ARB_IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = rel_ptr;
                end else if (accept) begin
                    cnt_nxt = beat_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            gnt      <= '0;
            owner    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: random sources with beat queues, checked
// against a grant/burst model of the arbitration rules.
module tb_rr_bus_arbiter;

    localparam int N  = 4;
    localparam int DW = 3;
    localparam int MB = 4;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  gnt;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [PW-1:0] out_src;
    logic          out_ready;

    always #5 clk = ~clk;

    rr_bus_arbiter #(
        .NUM_REQ(N),
        .DATA_W(DW),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_src(out_src),
        .out_ready(out_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Each source holds a queue of pending beats; req = non-empty.
    logic [DW-1:0] q[N][$];

    // Model: m_own = current grantee (-1 idle), m_last = last grantee,
    // m_ptr = next round-robin start, m_cnt = beats taken this grant.
    int m_own  = -1;
    int m_last = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;

    task automatic step(input bit r, input bit rdy);
        logic [N-1:0]    rq;
        logic [N*DW-1:0] rd;
        bit ev;
        bit acc;
        int base;
        int j;
        rq = '0;
        rd = '0;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                rq[i] = 1'b1;
                rd[i*DW +: DW] = q[i][0];
            end
        end
        rst       = r;
        req       = rq;
        req_data  = rd;
        out_ready = rdy;
        #1;
        chk("gnt", gnt, (m_own >= 0) ? (1 << m_own) : 0);
        ev = (m_own >= 0) && !r && rq[m_own];
        chk("out_valid", out_valid, ev);
        chk("out_data", out_data,
            (m_own >= 0 && !r) ? rd[m_own*DW +: DW] : 0);
        chk("out_src", out_src, m_last);
        acc = ev && rdy;
        if (acc) void'(q[m_own].pop_front());
        if (r) begin
            m_own  = -1;
            m_last = 0;
            m_ptr  = 0;
            m_cnt  = 0;
        end else if (m_own < 0) begin
`ifdef RR_BUS_ARBITER_FIXED_PRIO_EN
            base = 0;
`else
            base = m_ptr;
`endif
            j = -1;
            for (int k = 0; k < N; k++) begin
                if (j < 0 && rq[(base + k) % N]) j = (base + k) % N;
            end
            if (j >= 0) begin
                m_own  = j;
                m_last = j;
                m_cnt  = 0;
            end
        end else if (!rq[m_own] || (acc && m_cnt == MB - 1)) begin
`ifdef RR_BUS_ARBITER_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (m_own + 1) % N;
`endif
            m_own = -1;
        end else if (acc) begin
            m_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic refill(input int pct);
        int len;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() == 0 && $urandom_range(99) < pct) begin
                len = $urandom_range(6, 1);
                for (int b = 0; b < len; b++)
                    q[i].push_back(DW'($urandom));
            end
        end
    endtask

    task automatic top_up(input int lvl);
        for (int i = 0; i < N; i++)
            while (q[i].size() < lvl) q[i].push_back(DW'($urandom));
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        top_up(20);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int c = 0; c < 45; c++) begin
            top_up(10);
            step(1'b0, 1'b1);
        end
        for (int c = 0; c < 1500; c++) begin
            refill(30);
            step($urandom_range(99) < 1, $urandom_range(99) < 70);
        end
        for (int c = 0; c < 300; c++) begin
            refill(50);
            step(1'b0, $urandom_range(99) < 20);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
